sqrt_scheduler: RTL and testbench
=================================

# sqrt_scheduler

Round-robin scheduler that shares the single square-root unit of the calculator datapath between `N_REQ` requesters (keypad evaluator, display formatter, etc.). It accepts one operand at a time through a valid/ready handshake and drives the unit's level-sensitive `start`. It captures root and remainder on `done` and releases `start` so the unit returns to its idle/load state. It returns a one-cycle tagged response and recovers the unit via a watchdog if `done` never arrives.

## Interface
- `N_REQ`, 2: number of requesters (2..8)
- `WIDTH`, 16: operand width (even); root is `WIDTH/2`, remainder is `WIDTH/2+1`
- `TIMEOUT_CYC`, 64: cycles in ISSUE without `sq_done` before abort
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N_REQ: per-requester request
- `req_operand` in N_REQ*WIDTH: packed operands; slice i belongs to requester i
- `req_ready` out N_REQ: one-hot accept, valid only in IDLE
- `sq_start` out 1: level start to sqrt unit
- `sq_operand` out WIDTH: latched operand to sqrt unit
- `sq_rst` out 1: one-cycle pulse, OR-ed into sqrt unit reset on abort
- `sq_done` in 1: unit done level (held until `start` drops)
- `sq_root` in WIDTH/2: unit root
- `sq_rem` in WIDTH/2+1: unit remainder
- `resp_valid` out 1: one-cycle response pulse
- `resp_id` out clog2(N_REQ): requester index of response
- `resp_root` out WIDTH/2: captured root
- `resp_rem` out WIDTH/2+1: captured remainder
- `resp_err` out 1: response is a timeout abort (root/rem = 0)
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, ISSUE, RELEASE, ABORT, RESPOND.
- IDLE:
  - The grant goes to the first `req_valid` bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready[g]` is high combinationally in the same cycle. The handshake completes when valid and ready are both high.
  - On completion, latch `req_operand[g]` into `sq_operand`, latch `g` into `id_q`, set `rr_ptr <= (g+1) mod N_REQ`, and go to ISSUE.
  - With no valid bit set, stay in IDLE and leave `rr_ptr` unchanged.
- ISSUE: `sq_start=1` and the watchdog counts up from 0.
  - On `sq_done=1`: capture `sq_root`/`sq_rem` and go to RELEASE.
  - If the count reaches `TIMEOUT_CYC-1` without `sq_done`: go to ABORT.
- RELEASE: `sq_start=0`. Wait until `sq_done=0`, then go to RESPOND. This guarantees the unit is back in its load state before the next issue.
- ABORT: `sq_rst=1` for exactly one cycle, `sq_start=0`, captured root/rem cleared, error flag set. Next state is RESPOND.
- RESPOND:
  - `resp_valid=1` for one cycle, with `resp_id=id_q` and `resp_err` set only if the transaction came through ABORT.
  - Go to IDLE, clearing the error flag.
- Response path has no backpressure; requesters must sample `resp_valid`.
- Requesters hold `req_valid` and operand until ready. Dropping `req_valid` before ready loses nothing; that requester is simply not granted.
- Only one transaction is in flight. `req_ready` is all-zero outside IDLE.

## Timing
- Reset value of every output:
  - `req_ready`, `sq_start`, `sq_rst`, `resp_valid`, `resp_err`, `busy` = 0.
  - `sq_operand`, `resp_id`, `resp_root`, `resp_rem` = 0.
  - `rr_ptr` = 0; state = IDLE.
- `rst` high in any state forces IDLE on the next edge and drops `sq_start` that cycle. No response is produced for the in-flight request.
- Transaction timeline:
  - Handshake at edge T puts ISSUE and `sq_start=1` in T+1.
  - `sq_done` seen at edge D means RELEASE in D+1, and RESPOND one cycle after `sq_done` is low.
  - Minimum turnaround is 4 cycles plus unit latency. The next grant is possible the cycle after `resp_valid`.
- If `sq_done` is already high on ISSUE entry (stale), it is accepted. This is a unit error case and is not filtered.
- Simultaneous `sq_done` and watchdog expiry: `sq_done` wins.
- `resp_*` data fields hold their value until the next RESPOND. Only `resp_valid` pulses.

## Structure
- Shared package `calc_pkg`: state encoding localparams (IDLE=0, ISSUE=1, RELEASE=2, ABORT=3, RESPOND=4) and the default `WIDTH`.
- Sub-module `rr_arbiter` (`N_REQ`): inputs `req`, `ptr`; outputs one-hot `grant` and index `gidx`, purely combinational.
- The FSM, watchdog counter, operand/result registers and `rr_ptr` live in `sqrt_scheduler`.

## Test plan
- Requester 0, operand 144, behavioural unit with 24-cycle latency -> `sq_start` high until `done`, then `resp_valid` with id 0, root 12, rem 0, err 0.
- Requester 1, operand 150 -> id 1, root 12, rem 6. Operand 65535 -> root 255, rem 510.
- Both requesters valid continuously -> grants alternate 0,1,0,1. `rr_ptr` rotates and no requester is served twice in a row.
- Unit stub that never asserts `done` -> after 64 ISSUE cycles `sq_rst` pulses once, then `resp_valid` with `resp_err=1`, root 0, rem 0. Next request proceeds normally.
- Unit holds `done` 5 cycles after `start` drops -> scheduler stays in RELEASE and no grant occurs until `done` falls.
- `rst` asserted mid-ISSUE -> next cycle `sq_start=0`, `busy=0`, no `resp_valid`, `rr_ptr=0`.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared scheduler state encoding and default operand width for the calculator datapath
package calc_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RESPOND = 3'd4
  } sched_state_e;
endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    gidx
);
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    gidx = '0;
    // Scan farthest-first so the closest requester at or after ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (((req >> j) & N_REQ'(1)) != '0) begin
        grant = N_REQ'(1) << j;
        gidx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: round-robin sharing of one square-root unit with watchdog abort and tagged responses
module sqrt_scheduler
  import calc_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT_CYC = 64,
  parameter int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_operand,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   sq_start,
  output logic [WIDTH-1:0]       sq_operand,
  output logic                   sq_rst,
  input  logic                   sq_done,
  input  logic [WIDTH/2-1:0]     sq_root,
  input  logic [WIDTH/2:0]       sq_rem,
  output logic                   resp_valid,
  output logic [IW-1:0]          resp_id,
  output logic [WIDTH/2-1:0]     resp_root,
  output logic [WIDTH/2:0]       resp_rem,
  output logic                   resp_err,
  output logic                   busy
);
  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  sched_state_e     state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d, id_q, id_d, resp_id_q, resp_id_d, gidx;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] opnd_q, opnd_d, opnd_sel;
  logic [RW-1:0]    root_q, root_d, resp_root_q, resp_root_d;
  logic [RW:0]      rem_q, rem_d, resp_rem_q, resp_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d, hs, ld_resp;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req  (req_valid),
    .ptr  (rr_q),
    .grant(grant),
    .gidx (gidx)
  );

  assign req_ready  = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign hs         = |(req_valid & req_ready);
  assign opnd_sel   = WIDTH'(req_operand >> (WIDTH * int'(gidx)));
  assign sq_start   = state_q == ST_ISSUE;
  assign sq_rst     = state_q == ST_ABORT;
  assign sq_operand = opnd_q;
  assign resp_valid = state_q == ST_RESPOND;
  assign resp_err   = resp_valid & err_q;
  assign resp_id    = resp_id_q;
  assign resp_root  = resp_root_q;
  assign resp_rem   = resp_rem_q;
  assign busy       = state_q != ST_IDLE;

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    opnd_d = opnd_q;
    root_d = root_q;
    rem_d = rem_q;
    err_d = err_q;
    cnt_d = (state_q == ST_ISSUE) ? cnt_q + CW'(1) : '0;
    case (state_q)
      ST_IDLE: if (hs) begin
        state_d = ST_ISSUE;
        opnd_d = opnd_sel;
        id_d = gidx;
        rr_d = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
      end
      ST_ISSUE: if (sq_done) begin
        state_d = ST_RELEASE;
        root_d = sq_root;
        rem_d = sq_rem;
      end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_ABORT;
      end
      ST_RELEASE: state_d = sq_done ? ST_RELEASE : ST_RESPOND;
      ST_ABORT: begin
        state_d = ST_RESPOND;
        root_d = '0;
        rem_d = '0;
        err_d = 1'b1;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        err_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Response fields only change on entry to RESPOND so they hold across the next transaction
    ld_resp = state_d == ST_RESPOND && state_q != ST_RESPOND;
    resp_id_d = ld_resp ? id_q : resp_id_q;
    resp_root_d = ld_resp ? root_d : resp_root_q;
    resp_rem_d = ld_resp ? rem_d : resp_rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q <= '0;
      id_q <= '0;
      opnd_q <= '0;
      root_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      resp_id_q <= '0;
      resp_root_q <= '0;
      resp_rem_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      opnd_q <= opnd_d;
      root_q <= root_d;
      rem_q <= rem_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      resp_id_q <= resp_id_d;
      resp_root_q <= resp_root_d;
      resp_rem_q <= resp_rem_d;
    end
  end
endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb_sqrt_scheduler: directed table-driven bench with a behavioural sqrt unit of configurable latency
module tb_sqrt_scheduler;
  localparam int N = 2;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_operand;
  logic           sq_start, sq_rst, sq_done;
  logic [W-1:0]   sq_operand;
  logic [7:0]     sq_root, resp_root;
  logic [8:0]     sq_rem, resp_rem;
  logic           resp_valid, resp_err, busy;
  logic           resp_id;

  int lat, hold, never;
  int u_cnt, u_hold;
  int pass_n, tot_n;
  int n_cyc, n_start, n_rst, n_ready_bad;
  logic ok;

  always #5 clk = ~clk;

  sqrt_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .sq_start(sq_start), .sq_operand(sq_operand),
    .sq_rst(sq_rst), .sq_done(sq_done), .sq_root(sq_root), .sq_rem(sq_rem),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_root(resp_root),
    .resp_rem(resp_rem), .resp_err(resp_err), .busy(busy)
  );

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural unit: done after lat start cycles, held until start drops plus hold extra cycles
  always @(posedge clk) begin
    if (rst || sq_rst) begin
      u_cnt <= 0;
      u_hold <= 0;
      sq_done <= 1'b0;
      sq_root <= '0;
      sq_rem <= '0;
    end else if (sq_start && !sq_done && never == 0) begin
      if (u_cnt >= lat - 1) begin
        sq_done <= 1'b1;
        sq_root <= 8'(isqrt(int'(sq_operand)));
        sq_rem <= 9'(int'(sq_operand) - isqrt(int'(sq_operand)) ** 2);
      end else u_cnt <= u_cnt + 1;
    end else if (!sq_start && sq_done) begin
      if (u_hold >= hold) begin
        sq_done <= 1'b0;
        u_cnt <= 0;
        u_hold <= 0;
      end else u_hold <= u_hold + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run_req(input int id, input logic [15:0] op);
    @(negedge clk);
    req_valid = req_valid | N'(1 << id);
    req_operand[id*W +: W] = op;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("grant", 32'(ok), 1);
    n_cyc = 0;
    n_start = 0;
    n_rst = 0;
    n_ready_bad = 0;
    if (ok) begin
      @(posedge clk);
      #1 req_valid = req_valid & ~N'(1 << id);
      while (n_cyc < 300) begin
        @(negedge clk);
        n_cyc++;
        n_start += int'(sq_start);
        n_rst += int'(sq_rst);
        if (resp_valid) break;
        if (req_ready != '0) n_ready_bad++;
      end
    end
    chk("resp_seen", 32'(resp_valid), 1);
  endtask

  typedef struct {
    int id;
    logic [15:0] op;
    int root;
    int rem;
    int lat;
  } vec_t;
  vec_t v[6];

  initial begin
    v[0] = '{0, 16'd144, 12, 0, 24};
    v[1] = '{1, 16'd150, 12, 6, 24};
    v[2] = '{0, 16'd65535, 255, 510, 5};
    v[3] = '{1, 16'd0, 0, 0, 1};
    v[4] = '{0, 16'd99, 9, 18, 3};
    v[5] = '{1, 16'd255, 15, 30, 2};
    pass_n = 0;
    tot_n = 0;
    lat = 4;
    hold = 0;
    never = 0;
    rst = 1'b1;
    req_valid = '0;
    req_operand = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ctl", {sq_start, sq_rst, resp_valid, resp_err, busy}, 0);
    chk("rst_data", {sq_operand, resp_root, resp_rem, resp_id}, 0);
    rst = 1'b0;

    foreach (v[i]) begin
      lat = v[i].lat;
      run_req(v[i].id, v[i].op);
      chk("resp_id", 32'(resp_id), v[i].id);
      chk("resp_root", 32'(resp_root), v[i].root);
      chk("resp_rem", 32'(resp_rem), v[i].rem);
      chk("resp_err", 32'(resp_err), 0);
      chk("start_cycles", n_start, v[i].lat + 1);
      chk("turnaround", n_cyc, v[i].lat + 4);
    end

    never = 1;
    run_req(1, 16'd100);
    chk("to_start_cycles", n_start, 64);
    chk("to_sq_rst_pulses", n_rst, 1);
    chk("to_turnaround", n_cyc, 66);
    chk("to_err", 32'(resp_err), 1);
    chk("to_root", 32'(resp_root), 0);
    chk("to_rem", 32'(resp_rem), 0);
    chk("to_id", 32'(resp_id), 1);
    never = 0;
    lat = 6;
    run_req(0, 16'd144);
    chk("post_to_err", 32'(resp_err), 0);
    chk("post_to_root", 32'(resp_root), 12);
    chk("post_to_turnaround", n_cyc, 10);

    lat = 24;
    @(negedge clk);
    req_valid = 2'b01;
    req_operand[W-1:0] = 16'd144;
    #1 chk("mid_rst_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(negedge clk);
    chk("mid_rst_start_before", 32'(sq_start), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {sq_start, busy, resp_valid}, 0);
    rst = 1'b0;
    n_cyc = 0;
    repeat (40) begin
      @(negedge clk);
      n_cyc += int'(resp_valid);
    end
    chk("mid_rst_no_resp", n_cyc, 0);
    req_valid = 2'b11;
    #1 chk("mid_rst_ptr0", 32'(req_ready), 1);
    req_valid = '0;

    lat = 2;
    @(negedge clk);
    req_operand = {16'd150, 16'd144};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (resp_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (i == 3) req_valid = '0;
      chk("rr_resp_seen", 32'(ok), 1);
      chk("rr_id", 32'(resp_id), i % 2);
      chk("rr_rem", 32'(resp_rem), (i % 2) ? 6 : 0);
    end

    lat = 4;
    hold = 5;
    @(negedge clk);
    req_valid = 2'b10;
    req_operand[2*W-1:W] = 16'd150;
    run_req(0, 16'd65535);
    req_valid = '0;
    chk("hold_id", 32'(resp_id), 0);
    chk("hold_root", 32'(resp_root), 255);
    chk("hold_turnaround", n_cyc, 13);
    chk("hold_no_grant", n_ready_bad, 0);
    hold = 0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
